// File: rtl/seg_scanner.sv
// rtl/seg_scanner.sv - four-digit multiplexed seven-segment scanner with blanking and a double-buffered frame
module seg_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_in0,
  input  logic [7:0] seg_in1,
  input  logic [7:0] seg_in2,
  input  logic [7:0] seg_in3,
  input  logic       frame_valid,
  output logic       frame_ready,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic       frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [7:0]    r_act [4];
  logic [7:0]    r_shd [4];
  logic          r_full;
  logic [3:0]    r_an;
  logic [7:0]    r_seg;
  logic          r_done;

  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_idx_nxt;
  logic          w_wrap;
  logic          w_boundary;
  logic          w_accept;
  logic          w_blank_nxt;

  always_comb begin
    w_wrap      = (r_cnt == CNT_MAX);
    w_boundary  = w_wrap && (r_idx == 2'd3);
    w_cnt_nxt   = w_wrap ? '0 : r_cnt + 1'b1;
    w_idx_nxt   = w_wrap ? r_idx + 2'd1 : r_idx;
    w_accept    = frame_valid && !r_full;
    w_blank_nxt = (w_cnt_nxt < BLANK_END);
  end

  // Pin registers are loaded from the upcoming cnt/idx so they line up with the slot they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_an   <= 4'b1111;
      r_seg  <= 8'hFF;
      r_done <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_idx  <= w_idx_nxt;
      r_an   <= w_blank_nxt ? 4'b1111 : ~(4'b0001 << w_idx_nxt);
      r_seg  <= w_blank_nxt ? 8'hFF : r_act[w_idx_nxt];
      r_done <= (w_idx_nxt == 2'd3) && (w_cnt_nxt == CNT_MAX);
    end
  end

  // Active frame only swaps at the scan boundary; a shadow accepted on that same edge waits one scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_act[i] <= 8'hFF;
        r_shd[i] <= 8'hFF;
      end
    end else begin
      if (w_boundary && r_full) begin
        for (int i = 0; i < 4; i++) r_act[i] <= r_shd[i];
        r_full <= 1'b0;
      end
      if (w_accept) begin
        r_shd[0] <= seg_in0;
        r_shd[1] <= seg_in1;
        r_shd[2] <= seg_in2;
        r_shd[3] <= seg_in3;
        r_full   <= 1'b1;
      end
    end
  end

  assign frame_ready = !r_full;
  assign an          = r_an;
  assign seg         = r_seg;
  assign frame_done  = r_done;

endmodule

// File: doc/seg_scanner.md
SEG_SCANNER -- requirements
Module: seg_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz).
REQ-002 Parameter BLANK_CYCLES, default 1000, blanking cycles at the start of each slot (anti-ghosting).
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 seg_in0..seg_in3  input  8 each  active-low segment patterns for digits 0..3 (8'hFF = dark), same encoding as the blinking stage outputs.
REQ-006 frame_valid  input  1  producer offers seg_in0..3 as one frame.
REQ-007 frame_ready  output  1  shadow register empty; frame accepted on any cycle with frame_valid && frame_ready.
REQ-008 an  output  4  active-low digit anodes; an[i] low selects digit i.
REQ-009 seg  output  8  active-low cathodes for the selected digit.
REQ-010 frame_done  output  1  one-cycle pulse at the end of each full four-digit scan.

Function
REQ-011 Legal parameters are BLANK_CYCLES >= 1 and REFRESH_DIV >= BLANK_CYCLES + 2; the slot counter width is the minimum that holds REFRESH_DIV-1.
REQ-012 State: slot counter cnt (0..REFRESH_DIV-1), digit index idx (0..3), active frame A[0..3], shadow frame S[0..3], shadow_full flag.
REQ-013 cnt increments every cycle and wraps from REFRESH_DIV-1 to 0; on wrap, idx advances 0->1->2->3->0.
REQ-014 Phases: BLANK while cnt < BLANK_CYCLES (an=4'b1111, seg=8'hFF); DRIVE otherwise (an = one-cold at bit idx, seg = A[idx]).
REQ-015 an and seg are registered; they reflect the cnt/idx value in effect during the same cycle, so there are no combinational glitches on the pins.
REQ-016 The anode changes only through a BLANK phase; two anodes are never low in the same cycle.
REQ-017 frame_ready = !shadow_full (combinational from the flag).
REQ-018 Accept: frame_valid && frame_ready captures seg_in0..3 into S and sets shadow_full on the next edge.
REQ-019 Frame boundary: the cycle with idx==3 and cnt==REFRESH_DIV-1.
REQ-020 At the boundary, frame_done=1 for exactly that cycle.
REQ-021 At the boundary, if shadow_full, A<=S and shadow_full<=0; otherwise A is unchanged, so the display holds the last frame indefinitely.
REQ-022 A is never updated mid-scan; all four digits of one scan come from the same frame.
REQ-023 Accept at the boundary with the shadow empty: the new frame goes to S and is displayed from the following boundary, not the current one.
REQ-024 frame_valid while the shadow is full is ignored (no overwrite); the producer holds its data until frame_ready.
REQ-025 seg_in values are sampled only on accept; changes at other times have no effect.

Reset
REQ-026 While rst=1 at an edge: cnt=0, idx=0, A[0..3]=8'hFF, S=8'hFF, shadow_full=0, an=4'b1111, seg=8'hFF, frame_done=0.
REQ-027 Reset mid-scan or mid-handshake discards S and A. The first cycle with rst=0 is cnt=0, idx=0 (BLANK). frame_valid is ignored on cycles where rst=1.
REQ-028 After reset, frame_ready=1.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-029 Reset release with no frame -> an=1111 and seg=FF every cycle; frame_done pulses every 32 cycles, first on cycle 31 after release.
REQ-030 Accept frame {C0,F9,A4,B0} on cycle 3 -> S loaded and frame_ready=0; digits stay dark through cycle 31. From cycle 32: cycles 32-33 an=1111; cycles 34-39 an=1110, seg=C0; cycles 40-41 blank; cycles 42-47 an=1101, seg=F9; the pattern continues for digits 2 and 3; frame_ready=1 again from cycle 32.
REQ-031 Second frame offered while the shadow is full -> frame_ready stays 0 and A is unchanged. Hold frame_valid -> accepted on the first cycle after the swap, then displayed one scan later.
REQ-032 frame_valid asserted exactly on the boundary cycle with the shadow empty -> frame_done=1 and the old frame continues for the next scan; the new frame appears at the boundary after that.
REQ-033 rst pulsed on cycle 45 during DRIVE of digit 1 -> the next cycle shows an=1111, seg=FF and frame_ready=1; the scan restarts at idx 0, cnt 0 and the display stays dark until a new frame is accepted and swapped in.
REQ-034 Throughout all scenarios, a checker confirms that an is never anything other than 1111 or one-cold, and that an changes only from or to 1111.
